// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter for SLL/SRL/SRA/ROTR: log2(WIDTH) power-of-two mux levels,
// grouped LEVELS_PER_STAGE per register stage, moved as one globally stalled pipeline.
module pipelined_barrel_shifter #(
  parameter  int WIDTH            = 32,
  parameter  int LEVELS_PER_STAGE = 2,
  parameter  int TAG_W            = 5,
  localparam int SHAMT_W          = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);

  localparam int LAT = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  // Applies only the levels in [lo, hi); each selected level k moves the data by 2^k.
  function automatic logic [WIDTH-1:0] shift_levels(
    input logic [WIDTH-1:0]   d,
    input logic [SHAMT_W-1:0] sh,
    input logic [1:0]         op,
    input logic               sign,
    input int                 lo,
    input int                 hi
  );
    logic [WIDTH-1:0] v;
    int               amt;
    v = d;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (k >= lo && k < hi && sh[k]) begin
        amt = 1 << k;
        case (op_e'(op))
          OP_SLL:  v = v << amt;
          OP_SRL:  v = v >> amt;
          OP_SRA:  v = (v >> amt) | (sign ? ~({WIDTH{1'b1}} >> amt) : '0);
          default: v = (v >> amt) | (v << (WIDTH - amt));
        endcase
      end
    end
    return v;
  endfunction

  logic [WIDTH-1:0]   r_data  [LAT];
  logic [SHAMT_W-1:0] r_shamt [LAT];
  logic [1:0]         r_op    [LAT];
  logic               r_sign  [LAT];
  logic [TAG_W-1:0]   r_tag   [LAT];
  logic [LAT-1:0]     r_valid;
  logic               r_zero;

  // Index s is the input of stage s; index 0 is the block input itself.
  logic [WIDTH-1:0]   w_in_data  [LAT+1];
  logic [SHAMT_W-1:0] w_in_shamt [LAT+1];
  logic [1:0]         w_in_op    [LAT+1];
  logic               w_in_sign  [LAT+1];
  logic [TAG_W-1:0]   w_in_tag   [LAT+1];
  logic [WIDTH-1:0]   w_nxt_data [LAT];
  logic               w_advance;

  // Handshake: a beat transfers on valid && ready at the clock edge. The pipeline
  // moves as a unit: it advances whenever the output slot is empty or being taken,
  // in_ready is exactly that condition, and while stalled every stage holds.
  assign w_advance = out_ready || !r_valid[LAT-1];
  assign in_ready  = w_advance;

  always_comb begin
    w_in_data[0]  = in_data;
    w_in_shamt[0] = in_shamt;
    w_in_op[0]    = in_op;
    w_in_sign[0]  = in_data[WIDTH-1];
    w_in_tag[0]   = in_tag;
    for (int s = 0; s < LAT; s++) begin
      w_in_data[s+1]  = r_data[s];
      w_in_shamt[s+1] = r_shamt[s];
      w_in_op[s+1]    = r_op[s];
      w_in_sign[s+1]  = r_sign[s];
      w_in_tag[s+1]   = r_tag[s];
      w_nxt_data[s]   = shift_levels(w_in_data[s], w_in_shamt[s], w_in_op[s], w_in_sign[s],
                                     s * LEVELS_PER_STAGE, (s + 1) * LEVELS_PER_STAGE);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int s = 0; s < LAT; s++) begin
        r_data[s]  <= '0;
        r_shamt[s] <= '0;
        r_op[s]    <= '0;
        r_sign[s]  <= 1'b0;
        r_tag[s]   <= '0;
      end
      r_valid <= '0;
      r_zero  <= 1'b0;
    end else if (w_advance) begin
      for (int s = 0; s < LAT; s++) begin
        r_data[s]  <= w_nxt_data[s];
        r_shamt[s] <= w_in_shamt[s];
        r_op[s]    <= w_in_op[s];
        r_sign[s]  <= w_in_sign[s];
        r_tag[s]   <= w_in_tag[s];
      end
      r_valid <= (r_valid << 1) | LAT'(in_valid);
      r_zero  <= (w_nxt_data[LAT-1] == '0);
    end
  end

  assign out_valid = r_valid[LAT-1];
  assign out_data  = r_data[LAT-1];
  assign out_tag   = r_tag[LAT-1];
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: three configurations (32/2, 64/1, 8/3) exercised in
// turn against an arithmetic shift/rotate model through an accept/emit scoreboard.
module tb_pipelined_barrel_shifter;

  localparam int NC = 3;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        zero;
    logic [31:0] cyc;
  } beat_t;

  logic        clock;
  logic        resetn;
  logic        in_valid  [NC];
  logic        out_ready [NC];
  logic [63:0] in_data   [NC];
  logic [5:0]  in_shamt  [NC];
  logic [1:0]  in_op     [NC];
  logic [4:0]  in_tag    [NC];
  logic        in_ready  [NC];
  logic        out_valid [NC];
  logic        out_zero  [NC];
  logic [63:0] out_data  [NC];
  logic [4:0]  out_tag   [NC];

  logic        w0_in_ready, w0_out_valid, w0_out_zero;
  logic [31:0] w0_out_data;
  logic [4:0]  w0_out_tag;
  logic        w1_in_ready, w1_out_valid, w1_out_zero;
  logic [63:0] w1_out_data;
  logic [4:0]  w1_out_tag;
  logic        w2_in_ready, w2_out_valid, w2_out_zero;
  logic [7:0]  w2_out_data;
  logic [4:0]  w2_out_tag;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    cur;
  int    cyc;
  int    n_checks;
  int    n_fail;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got %0d, required 0 timeouts)", 1);
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) u_dut32 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid[0]), .in_ready(w0_in_ready), .in_data(in_data[0][31:0]),
    .in_shamt(in_shamt[0][4:0]), .in_op(in_op[0]), .in_tag(in_tag[0]),
    .out_valid(w0_out_valid), .out_ready(out_ready[0]), .out_data(w0_out_data),
    .out_tag(w0_out_tag), .out_zero(w0_out_zero));

  pipelined_barrel_shifter #(.WIDTH(64), .LEVELS_PER_STAGE(1), .TAG_W(5)) u_dut64 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid[1]), .in_ready(w1_in_ready), .in_data(in_data[1]),
    .in_shamt(in_shamt[1]), .in_op(in_op[1]), .in_tag(in_tag[1]),
    .out_valid(w1_out_valid), .out_ready(out_ready[1]), .out_data(w1_out_data),
    .out_tag(w1_out_tag), .out_zero(w1_out_zero));

  pipelined_barrel_shifter #(.WIDTH(8), .LEVELS_PER_STAGE(3), .TAG_W(5)) u_dut8 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid[2]), .in_ready(w2_in_ready), .in_data(in_data[2][7:0]),
    .in_shamt(in_shamt[2][2:0]), .in_op(in_op[2]), .in_tag(in_tag[2]),
    .out_valid(w2_out_valid), .out_ready(out_ready[2]), .out_data(w2_out_data),
    .out_tag(w2_out_tag), .out_zero(w2_out_zero));

  always_comb begin
    in_ready[0]  = w0_in_ready;  out_valid[0] = w0_out_valid; out_zero[0] = w0_out_zero;
    out_data[0]  = {32'h0, w0_out_data};  out_tag[0] = w0_out_tag;
    in_ready[1]  = w1_in_ready;  out_valid[1] = w1_out_valid; out_zero[1] = w1_out_zero;
    out_data[1]  = w1_out_data;  out_tag[1] = w1_out_tag;
    in_ready[2]  = w2_in_ready;  out_valid[2] = w2_out_valid; out_zero[2] = w2_out_zero;
    out_data[2]  = {56'h0, w2_out_data};  out_tag[2] = w2_out_tag;
  end

  // ---------------- reference model ----------------
  function automatic int cfg_w(input int c);
    return (c == 0) ? 32 : (c == 1) ? 64 : 8;
  endfunction

  function automatic int cfg_lat(input int c);
    return (c == 0) ? 3 : (c == 1) ? 6 : 1;
  endfunction

  function automatic logic [63:0] model(input int w, input logic [63:0] data,
                                        input int sh, input int op);
    logic [63:0] mask, d, r;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << w) - 64'h1);
    d    = data & mask;
    case (op)
      0:       r = (d << sh) & mask;
      1:       r = d >> sh;
      2:       r = (d >> sh) | (d[w-1] ? (mask & ~(mask >> sh)) : 64'h0);
      default: r = ((d >> sh) | (d << (w - sh))) & mask;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard feed ----------------
  always @(negedge clock) begin
    beat_t b;
    if (resetn === 1'b1) begin
      if (in_valid[cur] && in_ready[cur]) begin
        b.data = model(cfg_w(cur), in_data[cur], int'(in_shamt[cur]), int'(in_op[cur]));
        b.tag  = in_tag[cur];
        b.zero = (b.data == 64'h0);
        b.cyc  = cyc;
        exp_q.push_back(b);
      end
      if (out_valid[cur] && out_ready[cur]) begin
        b.data = out_data[cur];
        b.tag  = out_tag[cur];
        b.zero = out_zero[cur];
        b.cyc  = cyc;
        got_q.push_back(b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    for (int c = 0; c < NC; c++) begin
      in_valid[c]  = 1'b0;
      out_ready[c] = 1'b1;
      in_data[c]   = '0;
      in_shamt[c]  = '0;
      in_op[c]     = '0;
      in_tag[c]    = '0;
    end
  endtask

  task automatic send(input int c, input logic [63:0] d, input int sh, input int op, input int tag);
    in_valid[c] = 1'b1;
    in_data[c]  = d;
    in_shamt[c] = sh[5:0];
    in_op[c]    = op[1:0];
    in_tag[c]   = tag[4:0];
    for (int t = 0; t < 400; t++) begin
      @(negedge clock);
      if (in_ready[c]) break;
    end
    @(posedge clock);
    #1;
    in_valid[c] = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset(input int c);
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    n_checks++; if (out_valid[c] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid cfg%0d got=%b exp=0", c, out_valid[c]); end
    n_checks++; if (out_data[c] !== 64'h0) begin n_fail++; $display("FAIL reset_out_data cfg%0d got=%h exp=0", c, out_data[c]); end
    n_checks++; if (out_tag[c] !== 5'h0) begin n_fail++; $display("FAIL reset_out_tag cfg%0d got=%h exp=0", c, out_tag[c]); end
    n_checks++; if (out_zero[c] !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero cfg%0d got=%b exp=0", c, out_zero[c]); end
    n_checks++; if (in_ready[c] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready cfg%0d got=%b exp=1", c, in_ready[c]); end
  endtask

  task automatic test_directed(input int c);
    int          w;
    logic [63:0] msb;
    logic [63:0] vd [9];
    int          vs [9];
    int          vo [9];
    logic [31:0] lit32 [5];
    bit          ok;
    w   = cfg_w(c);
    msb = 64'h1 << (w - 1);
    vd[0] = 64'h1;    vs[0] = w - 1; vo[0] = 0;
    vd[1] = msb;      vs[1] = 4;     vo[1] = 2;
    vd[2] = msb;      vs[2] = 4;     vo[2] = 1;
    vd[3] = msb - 1;  vs[3] = w - 1; vo[3] = 2;
    vd[4] = 64'hF1;   vs[4] = 4;     vo[4] = 3;
    for (int i = 5; i < 9; i++) begin
      vd[i] = {$urandom, $urandom} | msb;
      vs[i] = 0;
      vo[i] = i - 5;
    end
    lit32[0] = 32'h8000_0000; lit32[1] = 32'hF800_0000; lit32[2] = 32'h0800_0000;
    lit32[3] = 32'h0000_0000; lit32[4] = 32'h1000_000F;
    for (int i = 0; i < 9; i++) begin
      exp_q.delete();
      got_q.delete();
      send(c, vd[i], vs[i], vo[i], i);
      wait_results(1, ok);
      n_checks++;
      if (!ok || exp_q.size() != 1) begin
        n_fail++; $display("FAIL directed_count cfg%0d vec%0d got=%0d exp=1", c, i, got_q.size());
      end else begin
        n_checks++; if (got_q[0].data !== exp_q[0].data) begin n_fail++; $display("FAIL directed_data cfg%0d vec%0d got=%h exp=%h", c, i, got_q[0].data, exp_q[0].data); end
        n_checks++; if (got_q[0].tag !== exp_q[0].tag) begin n_fail++; $display("FAIL directed_tag cfg%0d vec%0d got=%h exp=%h", c, i, got_q[0].tag, exp_q[0].tag); end
        n_checks++; if (got_q[0].zero !== exp_q[0].zero) begin n_fail++; $display("FAIL directed_zero cfg%0d vec%0d got=%b exp=%b", c, i, got_q[0].zero, exp_q[0].zero); end
        n_checks++; if (got_q[0].cyc - exp_q[0].cyc !== 32'(cfg_lat(c))) begin n_fail++; $display("FAIL directed_latency cfg%0d vec%0d got=%0d exp=%0d", c, i, got_q[0].cyc - exp_q[0].cyc, cfg_lat(c)); end
        if (c == 0 && i < 5) begin
          n_checks++; if (got_q[0].data[31:0] !== lit32[i]) begin n_fail++; $display("FAIL directed_literal vec%0d got=%h exp=%h", i, got_q[0].data[31:0], lit32[i]); end
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back(input int c);
    bit ok;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 8; i++)
      send(c, {$urandom, $urandom}, $urandom_range(0, cfg_w(c) - 1), $urandom_range(0, 3), i);
    wait_results(8, ok);
    n_checks++;
    if (!ok || exp_q.size() != 8) begin
      n_fail++; $display("FAIL b2b_count cfg%0d got=%0d/%0d exp=8", c, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (got_q[i].data !== exp_q[i].data) begin n_fail++; $display("FAIL b2b_data cfg%0d beat%0d got=%h exp=%h", c, i, got_q[i].data, exp_q[i].data); end
        n_checks++; if (got_q[i].tag !== 5'(i)) begin n_fail++; $display("FAIL b2b_tag cfg%0d beat%0d got=%0d exp=%0d", c, i, got_q[i].tag, i); end
        n_checks++; if (got_q[i].cyc !== got_q[0].cyc + 32'(i)) begin n_fail++; $display("FAIL b2b_rate cfg%0d beat%0d got=%0d exp=%0d", c, i, got_q[i].cyc, got_q[0].cyc + 32'(i)); end
      end
      n_checks++; if (got_q[0].cyc - exp_q[0].cyc !== 32'(cfg_lat(c))) begin n_fail++; $display("FAIL b2b_latency cfg%0d got=%0d exp=%0d", c, got_q[0].cyc - exp_q[0].cyc, cfg_lat(c)); end
    end
  endtask

  task automatic test_backpressure(input int c);
    bit          ok;
    logic [63:0] held;
    exp_q.delete();
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(c, {$urandom, $urandom}, $urandom_range(0, cfg_w(c) - 1), $urandom_range(0, 3), i + 8);
      end
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clock);
          if (out_valid[c]) break;
        end
        tick();
        tick();
        out_ready[c] = 1'b0;
        held = out_data[c];
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          n_checks++; if (in_ready[c] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cfg%0d cyc%0d got=%b exp=0", c, k, in_ready[c]); end
          n_checks++; if (out_valid[c] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cfg%0d cyc%0d got=%b exp=1", c, k, out_valid[c]); end
          n_checks++; if (out_data[c] !== held) begin n_fail++; $display("FAIL bp_hold cfg%0d cyc%0d got=%h exp=%h", c, k, out_data[c], held); end
          @(posedge clock);
        end
        #1;
        out_ready[c] = 1'b1;
      end
    join
    wait_results(12, ok);
    tick();
    n_checks++;
    if (!ok || got_q.size() != 12 || exp_q.size() != 12) begin
      n_fail++; $display("FAIL bp_count cfg%0d got=%0d/%0d exp=12", c, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_checks++; if (got_q[i].data !== exp_q[i].data || got_q[i].tag !== exp_q[i].tag) begin n_fail++; $display("FAIL bp_beat cfg%0d beat%0d got=%h/%0d exp=%h/%0d", c, i, got_q[i].data, got_q[i].tag, exp_q[i].data, exp_q[i].tag); end
      end
    end
  endtask

  task automatic test_reset_flush(input int c);
    for (int i = 0; i < 3; i++)
      send(c, {$urandom, $urandom} | 64'h1, 0, 0, 20 + i);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_checks++; if (out_valid[c] !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid cfg%0d got=%b exp=0", c, out_valid[c]); end
    n_checks++; if (out_data[c] !== 64'h0) begin n_fail++; $display("FAIL flush_out_data cfg%0d got=%h exp=0", c, out_data[c]); end
    exp_q.delete();
    got_q.delete();
    repeat (cfg_lat(c) + 4) tick();
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_stale cfg%0d got=%0d beats exp=0", c, got_q.size()); end
  endtask

  task automatic test_random(input int c);
    bit ok;
    int n;
    n = 150;
    exp_q.delete();
    got_q.delete();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          send(c, {$urandom, $urandom}, $urandom_range(0, cfg_w(c) - 1), $urandom_range(0, 3), $urandom_range(0, 31));
        end
      end
      begin
        for (int t = 0; t < 4000 && got_q.size() < n; t++) begin
          out_ready[c] = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready[c] = 1'b1;
      end
    join
    wait_results(n, ok);
    tick();
    n_checks++;
    if (!ok || got_q.size() != n || exp_q.size() != n) begin
      n_fail++; $display("FAIL random_count cfg%0d got=%0d/%0d exp=%0d", c, got_q.size(), exp_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (got_q[i].data !== exp_q[i].data || got_q[i].tag !== exp_q[i].tag || got_q[i].zero !== exp_q[i].zero) begin
          n_fail++; $display("FAIL random_beat cfg%0d beat%0d got=%h/%0d/%b exp=%h/%0d/%b", c, i, got_q[i].data, got_q[i].tag, got_q[i].zero, exp_q[i].data, exp_q[i].tag, exp_q[i].zero);
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cur      = 0;
    resetn   = 1'b0;
    idle_all();
    for (int c = 0; c < NC; c++) begin
      cur = c;
      idle_all();
      test_reset(c);
      test_directed(c);
      test_back_to_back(c);
      test_backpressure(c);
      test_reset_flush(c);
      test_random(c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
